// File: rtl/fifo_l1_buffer.sv
// Single-clock FIFO feeding one input of the layer-2 2:1 mux, with a registered read port and status flags.
// Define FIFO_COUNT_EN to expose the internal occupancy on the fill_count port.
module fifo_l1_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 2,
  parameter int AF_THRESH  = 3,
  parameter int AE_THRESH  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic                  error
`ifdef FIFO_COUNT_EN
  ,
  output logic [ADDR_WIDTH:0]   fill_count
`endif
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] depthLevel = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] afLevel    = (ADDR_WIDTH+1)'(AF_THRESH);
  localparam logic [ADDR_WIDTH:0] aeLevel    = (ADDR_WIDTH+1)'(AE_THRESH);

  // Thresholds that can never (or always) trigger are configuration mistakes; stop elaboration.
  if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : gBadAfThresh
    $error("fifo_l1_buffer: AF_THRESH out of range 1..DEPTH");
  end
  if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : gBadAeThresh
    $error("fifo_l1_buffer: AE_THRESH out of range 0..DEPTH-1");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wrPtr;
  logic [ADDR_WIDTH-1:0] rdPtr;
  logic [ADDR_WIDTH:0]   count;
  logic                  wrAccept;
  logic                  rdAccept;

  // Flags come straight from the registered count, so they trail each op by one cycle.
  assign empty        = (count == '0);
  assign full         = (count == depthLevel);
  assign almost_empty = (count <= aeLevel);
  assign almost_full  = (count >= afLevel);

  // A full FIFO never writes through and an empty one never bypasses a read.
  assign wrAccept = push && !full;
  assign rdAccept = pop && !empty;

`ifdef FIFO_COUNT_EN
  assign fill_count = count;
`endif

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wrAccept) begin
      mem[wrPtr] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (wrAccept) begin
        wrPtr <= wrPtr + 1'b1;
      end
      if (rdAccept) begin
        rdPtr <= rdPtr + 1'b1;
      end
      case ({wrAccept, rdAccept})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // ---- read stage: one-cycle registered output ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out  <= '0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= rdAccept;
      if (rdAccept) begin
        data_out <= mem[rdPtr];
      end
    end
  end

  // Overflow and underflow latch until the next reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      error <= 1'b0;
    end else if ((push && full) || (pop && empty)) begin
      error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_l1_buffer.sv
// Directed self-checking bench for fifo_l1_buffer with the default 8-bit x 4-deep configuration.
module tb_fifo_l1_buffer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       push = 1'b0;
  logic       pop = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out;
  logic       valid_out;
  logic       empty;
  logic       full;
  logic       almost_empty;
  logic       almost_full;
  logic       error;
`ifdef FIFO_COUNT_EN
  logic [2:0] fill_count;
`endif

  int nTests = 0;
  int nFail  = 0;

  fifo_l1_buffer #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(2),
    .AF_THRESH (3),
    .AE_THRESH (1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .push        (push),
    .data_in     (data_in),
    .pop         (pop),
    .data_out    (data_out),
    .valid_out   (valid_out),
    .empty       (empty),
    .full        (full),
    .almost_empty(almost_empty),
    .almost_full (almost_full),
    .error       (error)
`ifdef FIFO_COUNT_EN
    ,
    .fill_count  (fill_count)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pushWord(input logic [7:0] d);
    push = 1'b1;
    data_in = d;
    tick();
    push = 1'b0;
  endtask

  task automatic popWord();
    pop = 1'b1;
    tick();
    pop = 1'b0;
  endtask

  task automatic applyReset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    push = 1'b0;
    pop = 1'b0;
    tick();
    tick();
    nTests++;
    if ({empty, almost_empty, full, almost_full} !== 4'b1100) begin
      nFail++;
      $display("FAIL reset_flags got e/ae/f/af=%b want 1100", {empty, almost_empty, full, almost_full});
    end
    nTests++;
    if (valid_out !== 1'b0 || data_out !== 8'h00) begin
      nFail++;
      $display("FAIL reset_output got valid=%b data=%h want valid=0 data=00", valid_out, data_out);
    end
    nTests++;
    if (error !== 1'b0) begin
      nFail++;
      $display("FAIL reset_error got %b want 0", error);
    end
`ifdef FIFO_COUNT_EN
    nTests++;
    if (fill_count !== 3'd0) begin
      nFail++;
      $display("FAIL reset_count got %0d want 0", fill_count);
    end
`endif
    reset = 1'b1;
  endtask

  task automatic test_fill_drain();
    logic [7:0] vals [4];
    vals = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    for (int i = 0; i < 4; i++) begin
      pushWord(vals[i]);
      if (i == 2) begin
        nTests++;
        if ({full, almost_full} !== 2'b01) begin
          nFail++;
          $display("FAIL fill_af3 got full/af=%b want 01", {full, almost_full});
        end
      end
    end
    nTests++;
    if ({full, almost_full, empty} !== 3'b110) begin
      nFail++;
      $display("FAIL fill_full got full/af/empty=%b want 110", {full, almost_full, empty});
    end
    for (int i = 0; i < 4; i++) begin
      popWord();
      nTests++;
      if (valid_out !== 1'b1 || data_out !== vals[i]) begin
        nFail++;
        $display("FAIL drain_%0d got valid=%b data=%h want valid=1 data=%h", i, valid_out, data_out, vals[i]);
      end
    end
    nTests++;
    if ({empty, almost_empty, error} !== 3'b110) begin
      nFail++;
      $display("FAIL drain_empty got empty/ae/err=%b want 110", {empty, almost_empty, error});
    end
    tick();
    nTests++;
    if (valid_out !== 1'b0 || data_out !== 8'hD4) begin
      nFail++;
      $display("FAIL drain_hold got valid=%b data=%h want valid=0 data=d4", valid_out, data_out);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] vals [4];
    vals = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) pushWord(vals[i]);
    pushWord(8'hEE);
    nTests++;
    if (full !== 1'b1 || error !== 1'b1) begin
      nFail++;
      $display("FAIL ovf_flag got full=%b err=%b want full=1 err=1", full, error);
    end
    tick();
    nTests++;
    if (error !== 1'b1) begin
      nFail++;
      $display("FAIL ovf_sticky got err=%b want 1", error);
    end
    for (int i = 0; i < 4; i++) begin
      popWord();
      nTests++;
      if (valid_out !== 1'b1 || data_out !== vals[i]) begin
        nFail++;
        $display("FAIL ovf_pop_%0d got valid=%b data=%h want valid=1 data=%h", i, valid_out, data_out, vals[i]);
      end
    end
    nTests++;
    if (empty !== 1'b1 || error !== 1'b1) begin
      nFail++;
      $display("FAIL ovf_end got empty=%b err=%b want empty=1 err=1", empty, error);
    end
    applyReset();
    nTests++;
    if (error !== 1'b0 || data_out !== 8'h00) begin
      nFail++;
      $display("FAIL ovf_reset got err=%b data=%h want err=0 data=00", error, data_out);
    end
  endtask

  task automatic test_underflow();
    popWord();
    nTests++;
    if (valid_out !== 1'b0 || error !== 1'b1 || empty !== 1'b1 || data_out !== 8'h00) begin
      nFail++;
      $display("FAIL udf_pop got valid=%b err=%b empty=%b data=%h want 0 1 1 00", valid_out, error, empty, data_out);
    end
    pushWord(8'h5A);
    nTests++;
    if ({empty, almost_empty} !== 2'b01) begin
      nFail++;
      $display("FAIL udf_count got empty/ae=%b want 01", {empty, almost_empty});
    end
    popWord();
    nTests++;
    if (valid_out !== 1'b1 || data_out !== 8'h5A || empty !== 1'b1) begin
      nFail++;
      $display("FAIL udf_recover got valid=%b data=%h empty=%b want 1 5a 1", valid_out, data_out, empty);
    end
    applyReset();
  endtask

  task automatic test_simultaneous();
    logic [7:0] expd;
    pushWord(8'h01);
    pushWord(8'h02);
    for (int k = 0; k < 6; k++) begin
      push = 1'b1;
      pop = 1'b1;
      data_in = 8'(k + 3);
      tick();
      expd = 8'(k + 1);
      nTests++;
      if (valid_out !== 1'b1 || data_out !== expd ||
          {empty, almost_empty, almost_full, full} !== 4'b0000) begin
        nFail++;
        $display("FAIL both_%0d got valid=%b data=%h flags=%b want 1 %h 0000",
                 k, valid_out, data_out, {empty, almost_empty, almost_full, full}, expd);
      end
`ifdef FIFO_COUNT_EN
      nTests++;
      if (fill_count !== 3'd2) begin
        nFail++;
        $display("FAIL both_count_%0d got %0d want 2", k, fill_count);
      end
`endif
    end
    push = 1'b0;
    pop = 1'b0;
    popWord();
    nTests++;
    if (valid_out !== 1'b1 || data_out !== 8'h07) begin
      nFail++;
      $display("FAIL both_tail0 got valid=%b data=%h want 1 07", valid_out, data_out);
    end
    popWord();
    nTests++;
    if (valid_out !== 1'b1 || data_out !== 8'h08 || empty !== 1'b1 || error !== 1'b0) begin
      nFail++;
      $display("FAIL both_tail1 got valid=%b data=%h empty=%b err=%b want 1 08 1 0", valid_out, data_out, empty, error);
    end
    push = 1'b1;
    pop = 1'b1;
    data_in = 8'h99;
    tick();
    push = 1'b0;
    pop = 1'b0;
    nTests++;
    if (valid_out !== 1'b0 || data_out !== 8'h08 || error !== 1'b1 || {empty, almost_empty} !== 2'b01) begin
      nFail++;
      $display("FAIL both_empty got valid=%b data=%h err=%b empty/ae=%b want 0 08 1 01",
               valid_out, data_out, error, {empty, almost_empty});
    end
    popWord();
    nTests++;
    if (valid_out !== 1'b1 || data_out !== 8'h99) begin
      nFail++;
      $display("FAIL both_empty_pop got valid=%b data=%h want 1 99", valid_out, data_out);
    end
  endtask

  task automatic test_mid_reset();
    applyReset();
    pushWord(8'h61);
    pushWord(8'h62);
    pushWord(8'h63);
    pushWord(8'h64);
    popWord();
    nTests++;
    if (valid_out !== 1'b1 || data_out !== 8'h61 || almost_full !== 1'b1 || full !== 1'b0) begin
      nFail++;
      $display("FAIL mid_pre got valid=%b data=%h af=%b full=%b want 1 61 1 0", valid_out, data_out, almost_full, full);
    end
    #2;
    reset = 1'b0;
    #1;
    nTests++;
    if (valid_out !== 1'b0 || data_out !== 8'h00 ||
        {empty, almost_empty, full, almost_full} !== 4'b1100 || error !== 1'b0) begin
      nFail++;
      $display("FAIL mid_async got valid=%b data=%h flags=%b err=%b want 0 00 1100 0",
               valid_out, data_out, {empty, almost_empty, full, almost_full}, error);
    end
    reset = 1'b1;
    pushWord(8'h55);
    popWord();
    nTests++;
    if (valid_out !== 1'b1 || data_out !== 8'h55 || empty !== 1'b1) begin
      nFail++;
      $display("FAIL mid_after got valid=%b data=%h empty=%b want 1 55 1", valid_out, data_out, empty);
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_overflow();
    test_underflow();
    test_simultaneous();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
